// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer: flush FSM states,
// the weakly-taken counter seed and the saturating counter arithmetic.
package btb_pkg;

    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

    function automatic logic [31:0] weak_taken_init(input int cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] val);
        return (val == 32'd0) ? 32'd0 : val - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Combinational W-bit up/down saturating step; used for the direction
// counters and, at W=32, for the optional statistics counters.
module sat_counter
    import btb_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0] val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] nxt
);
    localparam logic [W-1:0] MAX_VAL = '1;

    always_comb begin
        nxt = val;
        if (inc)
            nxt = W'(sat_inc(32'(val), 32'(MAX_VAL)));
        else if (dec)
            nxt = W'(sat_dec(32'(val)));
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged branch target buffer with saturating direction counters
// and a one-entry-per-cycle flush sweep. Optional statistics: BTB_STATS_EN.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    output logic              ready,
    input  logic [ADDR_W-1:0] q_pc,
    output logic              q_hit,
    output logic              q_taken,
    output logic [ADDR_W-1:0] q_target,
    input  logic              u_valid,
    input  logic [ADDR_W-1:0] u_pc,
    input  logic              u_taken,
    input  logic [ADDR_W-1:0] u_target,
    input  logic              u_pred_taken,
    input  logic [ADDR_W-1:0] u_pred_target,
    output logic              mispredict
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              valid_mem [ENTRIES];
    logic [TAG_W-1:0]  tag_mem   [ENTRIES];
    logic [ADDR_W-1:0] tgt_mem   [ENTRIES];
    logic [CNT_W-1:0]  cnt_mem   [ENTRIES];

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  sweep_idx, sweep_idx_nxt;

    logic [IDX_W-1:0]  q_idx, u_idx;
    logic [TAG_W-1:0]  q_tag, u_tag;
    logic              u_hit;
    logic [CNT_W-1:0]  cnt_upd;
    logic              unused_pc_bits;

    assign q_idx = q_pc[IDX_W+1:2];
    assign q_tag = q_pc[ADDR_W-1:IDX_W+2];
    assign u_idx = u_pc[IDX_W+1:2];
    assign u_tag = u_pc[ADDR_W-1:IDX_W+2];
    assign unused_pc_bits = ^{q_pc[1:0], u_pc[1:0]};

    assign ready = (state == ST_IDLE);

    // Query sees registered contents only, so a same-cycle update is not bypassed.
    assign q_hit    = ready && valid_mem[q_idx] && (tag_mem[q_idx] == q_tag);
    assign q_taken  = q_hit && cnt_mem[q_idx][CNT_W-1];
    assign q_target = q_hit ? tgt_mem[q_idx] : '0;

    assign u_hit = valid_mem[u_idx] && (tag_mem[u_idx] == u_tag);
    assign mispredict = u_valid && ((u_pred_taken != u_taken) ||
                                    (u_taken && (u_pred_target != u_target)));

    sat_counter #(.W(CNT_W)) u_dir_cnt (
        .val (cnt_mem[u_idx]),
        .inc (u_taken),
        .dec (!u_taken),
        .nxt (cnt_upd)
    );

    always_comb begin
        state_nxt     = state;
        sweep_idx_nxt = sweep_idx;
        case (state)
            ST_IDLE: begin
                if (flush) begin
                    state_nxt     = ST_SWEEP;
                    sweep_idx_nxt = '0;
                end
            end
            ST_SWEEP: begin
                if (flush) begin
                    sweep_idx_nxt = '0;
                end else if (sweep_idx == IDX_W'(ENTRIES - 1)) begin
                    state_nxt     = ST_IDLE;
                    sweep_idx_nxt = '0;
                end else begin
                    sweep_idx_nxt = sweep_idx + 1'b1;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                sweep_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            sweep_idx <= '0;
        end else begin
            state     <= state_nxt;
            sweep_idx <= sweep_idx_nxt;
        end
    end

    // Sweep owns the table; resolved branches arriving meanwhile are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_mem[i] <= 1'b0;
                tag_mem[i]   <= '0;
                tgt_mem[i]   <= '0;
                cnt_mem[i]   <= '0;
            end
        end else if (state == ST_SWEEP) begin
            valid_mem[sweep_idx] <= 1'b0;
            cnt_mem[sweep_idx]   <= '0;
        end else if (u_valid) begin
            if (u_hit) begin
                cnt_mem[u_idx] <= cnt_upd;
                if (u_taken)
                    tgt_mem[u_idx] <= u_target;
            end else if (u_taken) begin
                valid_mem[u_idx] <= 1'b1;
                tag_mem[u_idx]   <= u_tag;
                tgt_mem[u_idx]   <= u_target;
                cnt_mem[u_idx]   <= CNT_W'(weak_taken_init(CNT_W));
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] branches_nxt, mispredicts_nxt;

    sat_counter #(.W(32)) u_stat_br (
        .val (stat_branches),
        .inc (u_valid),
        .dec (1'b0),
        .nxt (branches_nxt)
    );

    sat_counter #(.W(32)) u_stat_mis (
        .val (stat_mispredicts),
        .inc (mispredict),
        .dec (1'b0),
        .nxt (mispredicts_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_branches    <= branches_nxt;
            stat_mispredicts <= mispredicts_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed vector table, flush
// sequences, async reset checks and a randomized run against a reference model.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        ready;
    logic [11:0] q_pc = '0;
    logic        q_hit, q_taken;
    logic [11:0] q_target;
    logic        u_valid = 1'b0;
    logic [11:0] u_pc = '0;
    logic        u_taken = 1'b0;
    logic [11:0] u_target = '0;
    logic        u_pred_taken = 1'b0;
    logic [11:0] u_pred_target = '0;
    logic        mispredict;
`ifdef BTB_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    branch_target_buffer #(.ADDR_W(12), .ENTRIES(16), .CNT_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .ready         (ready),
        .q_pc          (q_pc),
        .q_hit         (q_hit),
        .q_taken       (q_taken),
        .q_target      (q_target),
        .u_valid       (u_valid),
        .u_pc          (u_pc),
        .u_taken       (u_taken),
        .u_target      (u_target),
        .u_pred_taken  (u_pred_taken),
        .u_pred_target (u_pred_target),
        .mispredict    (mispredict)
`ifdef BTB_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    typedef struct {
        logic [11:0] q;
        logic        uv;
        logic [11:0] upc;
        logic        ut;
        logic [11:0] utg;
        logic        upt;
        logic [11:0] uptg;
        logic        e_hit;
        logic        e_taken;
        logic [11:0] e_tgt;
        logic        e_mis;
    } vec_t;

    vec_t tbl[14];

    // Reference model: one record per index, counters as plain integers.
    int m_valid[16], m_tag[16], m_tgt[16], m_cnt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [11:0] q, input logic uv, input logic [11:0] upc,
                                input logic ut, input logic [11:0] utg, input logic upt,
                                input logic [11:0] uptg, input logic eh, input logic et,
                                input logic [11:0] etg, input logic em);
        vec_t v;
        v.q = q; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg; v.upt = upt; v.uptg = uptg;
        v.e_hit = eh; v.e_taken = et; v.e_tgt = etg; v.e_mis = em;
        return v;
    endfunction

    task automatic drive(input logic uv, input logic [11:0] upc, input logic ut,
                         input logic [11:0] utg, input logic upt, input logic [11:0] uptg);
        u_valid = uv; u_pc = upc; u_taken = ut; u_target = utg;
        u_pred_taken = upt; u_pred_target = uptg;
    endtask

    task automatic idle();
        drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000);
        flush = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_update(input logic uv, input logic [11:0] upc, input logic ut,
                                input logic [11:0] utg);
        int i, t;
        i = (int'(upc) / 4) % 16;
        t = int'(upc) / 64;
        if (!uv) return;
        if (m_valid[i] == 1 && m_tag[i] == t) begin
            if (ut) begin
                m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                m_tgt[i] = int'(utg);
            end else begin
                m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
        end else if (ut) begin
            m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = int'(utg); m_cnt[i] = 2;
        end
    endtask

    task automatic fill4();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            drive(1'b1, 12'(12'h100 + 4 * k), 1'b1, 12'(12'h300 + 4 * k), 1'b1, 12'(12'h300 + 4 * k));
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic check_all_miss(input string name);
        logic [11:0] pcs[5];
        pcs[0] = 12'h100; pcs[1] = 12'h104; pcs[2] = 12'h108; pcs[3] = 12'h10C; pcs[4] = 12'h200;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            q_pc = pcs[k];
            @(negedge clk);
            chk($sformatf("%s_hit_%0d", name, k), q_hit, 1'b0);
        end
    endtask

    // Pulses flush, optionally re-flushes or injects an update, returns ready=0 cycle count.
    task automatic run_sweep(input int reflush_at, input int upd_at, output int low);
        bit done;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        low = 0;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (ready) begin
                done = 1;
            end else begin
                low++;
                if (low == reflush_at) flush = 1'b1;
                if (low == upd_at) begin
                    q_pc = 12'h10C;
                    drive(1'b1, 12'h200, 1'b1, 12'h3F0, 1'b0, 12'h000);
                    #1;
                    chk("sweep_query_gated", q_hit, 1'b0);
                    chk("sweep_target_gated", q_target, 12'h000);
                    chk("sweep_mispredict", mispredict, 1'b1);
                end
                @(posedge clk); #1;
                idle();
            end
        end
        if (!done) chk("sweep_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low;
        int e_hit, e_taken, e_tgt, e_mis, i, t;
        logic [11:0] rq, rpc, rtg, rptg;
        logic ruv, rut, rupt;

        tbl[0]  = mk(12'h010, 0, 12'h000, 0, 12'h000, 0, 12'h000, 0, 0, 12'h000, 0);
        tbl[1]  = mk(12'h010, 1, 12'h010, 1, 12'h040, 0, 12'h000, 0, 0, 12'h000, 1);
        tbl[2]  = mk(12'h010, 0, 12'h000, 0, 12'h000, 0, 12'h000, 1, 1, 12'h040, 0);
        tbl[3]  = mk(12'h050, 0, 12'h000, 0, 12'h000, 1, 12'h000, 0, 0, 12'h000, 0);
        tbl[4]  = mk(12'h010, 1, 12'h010, 0, 12'h000, 1, 12'h040, 1, 1, 12'h040, 1);
        tbl[5]  = mk(12'h010, 1, 12'h010, 0, 12'h000, 0, 12'h000, 1, 0, 12'h040, 0);
        tbl[6]  = mk(12'h010, 1, 12'h010, 0, 12'h000, 0, 12'h000, 1, 0, 12'h040, 0);
        tbl[7]  = mk(12'h010, 0, 12'h000, 0, 12'h000, 0, 12'h000, 1, 0, 12'h040, 0);
        tbl[8]  = mk(12'h010, 1, 12'h010, 1, 12'h044, 1, 12'h040, 1, 0, 12'h040, 1);
        tbl[9]  = mk(12'h010, 0, 12'h000, 0, 12'h000, 0, 12'h000, 1, 0, 12'h044, 0);
        tbl[10] = mk(12'h020, 1, 12'h020, 1, 12'h080, 1, 12'h080, 0, 0, 12'h000, 0);
        tbl[11] = mk(12'h020, 0, 12'h000, 0, 12'h000, 0, 12'h000, 1, 1, 12'h080, 0);
        tbl[12] = mk(12'h024, 1, 12'h024, 0, 12'h000, 0, 12'h000, 0, 0, 12'h000, 0);
        tbl[13] = mk(12'h024, 0, 12'h000, 0, 12'h000, 0, 12'h000, 0, 0, 12'h000, 0);

        repeat (2) @(negedge clk);
        rst = 1'b1;
        q_pc = 12'h010;
        #1;
        chk("reset_ready", ready, 1'b1);
        chk("reset_hit", q_hit, 1'b0);
        chk("reset_taken", q_taken, 1'b0);
        chk("reset_target", q_target, 12'h000);

        for (int r = 0; r < 14; r++) begin
            @(posedge clk); #1;
            q_pc = tbl[r].q;
            drive(tbl[r].uv, tbl[r].upc, tbl[r].ut, tbl[r].utg, tbl[r].upt, tbl[r].uptg);
            @(negedge clk);
            chk($sformatf("row%0d_hit", r), q_hit, tbl[r].e_hit);
            chk($sformatf("row%0d_taken", r), q_taken, tbl[r].e_taken);
            chk($sformatf("row%0d_target", r), q_target, tbl[r].e_tgt);
            chk($sformatf("row%0d_mispredict", r), mispredict, tbl[r].e_mis);
            chk($sformatf("row%0d_ready", r), ready, 1'b1);
        end
        @(posedge clk); #1;
        idle();
        q_pc = 12'h010;
        @(negedge clk);
        chk("pre_areset_hit", q_hit, 1'b1);
        chk("pre_areset_target", q_target, 12'h044);
`ifdef BTB_STATS_EN
        chk("table_stat_branches", stat_branches, 32'd7);
        chk("table_stat_mispredicts", stat_mispredicts, 32'd3);
`endif
        #1 rst = 1'b0;
        #1;
        chk("areset_hit", q_hit, 1'b0);
        chk("areset_target", q_target, 12'h000);
        chk("areset_ready", ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;

`ifdef BTB_STATS_EN
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            drive(1'b1, 12'(12'h400 + 4 * k), 1'b1, 12'h500, (k < 3) ? 1'b0 : 1'b1,
                  (k == 5) ? 12'h504 : 12'h500);
        end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("stat_branches", stat_branches, 32'd10);
        chk("stat_mispredicts", stat_mispredicts, 32'd4);
        #2 rst = 1'b0;
        #1;
        chk("stat_branches_areset", stat_branches, 32'd0);
        chk("stat_mispredicts_areset", stat_mispredicts, 32'd0);
        @(negedge clk);
        rst = 1'b1;
`endif

        fill4();
        @(posedge clk); #1;
        q_pc = 12'h10C;
        @(negedge clk);
        chk("fill_hit", q_hit, 1'b1);
        chk("fill_target", q_target, 12'h30C);
        run_sweep(0, 2, low);
        chk("sweep_len", low, 16);
        check_all_miss("after_sweep");

        fill4();
        run_sweep(5, 0, low);
        chk("reflush_len", low, 21);
        check_all_miss("after_reflush");

        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_sweep_busy", ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_sweep_areset_ready", ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_abort_ready", ready, 1'b1);

        model_reset();
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            rq   = 12'(($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            rpc  = 12'(($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            ruv  = 1'($urandom_range(0, 3) != 0);
            rut  = 1'($urandom_range(0, 2) != 0);
            rtg  = 12'($urandom_range(0, 7) << 2);
            rupt = 1'($urandom_range(0, 1));
            rptg = ($urandom_range(0, 1) != 0) ? rtg : 12'($urandom_range(0, 7) << 2);
            q_pc = rq;
            drive(ruv, rpc, rut, rtg, rupt, rptg);
            @(negedge clk);
            i = (int'(rq) / 4) % 16;
            t = int'(rq) / 64;
            e_hit   = (m_valid[i] == 1 && m_tag[i] == t) ? 1 : 0;
            e_taken = (e_hit == 1 && m_cnt[i] >= 2) ? 1 : 0;
            e_tgt   = (e_hit == 1) ? m_tgt[i] : 0;
            e_mis   = (ruv && ((rupt != rut) || (rut && rptg != rtg))) ? 1 : 0;
            chk($sformatf("rand%0d_hit", n), q_hit, 32'(e_hit));
            chk($sformatf("rand%0d_taken", n), q_taken, 32'(e_taken));
            chk($sformatf("rand%0d_target", n), q_target, 32'(e_tgt));
            chk($sformatf("rand%0d_mispredict", n), mispredict, 32'(e_mis));
            model_update(ruv, rpc, rut, rtg);
        end
        @(posedge clk); #1;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised successor to the pipeline's branch history table: direct-mapped, tagged branch target buffer with per-entry N-bit saturating direction counters.
- IF stage queries it combinationally with pc+4 to pick the next fetch address.
- EXE stage writes back the resolved branch outcome.
- Adds, beyond the old table:
  - configurable depth, address width and counter width;
  - tag checking;
  - a multi-cycle flush sweep FSM;
  - optional misprediction statistics.

Parameters:
- ADDR_W, 12, instruction address width in bits (byte address, word aligned).
- ENTRIES, 16, number of entries; power of two, 2..256.
- CNT_W, 2, saturating counter width; predict taken when MSB=1.
- IDX_W, log2(ENTRIES), derived (localparam).
- TAG_W, ADDR_W-IDX_W-2, derived (localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  pulse; starts an invalidate sweep of all entries.
- ready  out  1  1 when idle; 0 during a sweep.
- q_pc  in  ADDR_W  query address (IF stage).
- q_hit  out  1  valid entry with matching tag.
- q_taken  out  1  q_hit AND counter MSB.
- q_target  out  ADDR_W  stored target; 0 when q_hit=0.
- u_valid  in  1  EXE resolved a branch/jump this cycle.
- u_pc  in  ADDR_W  address of the resolved instruction.
- u_taken  in  1  actual direction (1 for unconditional).
- u_target  in  ADDR_W  actual target.
- u_pred_taken  in  1  prediction carried down the pipe for this instruction.
- u_pred_target  in  ADDR_W  predicted target carried down the pipe.
- mispredict  out  1  combinational; u_valid AND (u_pred_taken!=u_taken OR (u_taken AND u_pred_target!=u_target)).

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[ADDR_W-1:IDX_W+2].
  - pc[1:0] ignored.
- Query:
  - Purely combinational from registered state; zero latency.
  - While ready=0: q_hit=0, q_taken=0, q_target=0.
- Update (posedge clk, u_valid=1, ready=1):
  - Hit (valid, tag match), taken: counter+1, saturating at 2^CNT_W-1; target <= u_target.
  - Hit, not taken: counter-1, saturating at 0; target unchanged.
  - Miss, taken: allocate (overwrite any occupant); valid=1, tag written, target=u_target, counter = 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change.
- Same-cycle query and update to the same index: query returns pre-update contents; no bypass. The new value is visible the next cycle.
- Flush FSM states:
  - IDLE → SWEEP on flush=1.
  - SWEEP clears valid[sweep_idx] and counter[sweep_idx] one entry per cycle, sweep_idx 0..ENTRIES-1.
  - SWEEP → IDLE after clearing entry ENTRIES-1. A sweep lasts exactly ENTRIES cycles; ready=1 on the cycle after the last clear.
  - flush=1 during SWEEP restarts sweep_idx at 0.
  - u_valid during SWEEP is dropped (no write). mispredict is still generated.
- Reset (rst=0), asynchronous:
  - all valid=0, counters=0, targets=0;
  - state=IDLE, sweep_idx=0, ready=1;
  - all query outputs 0.
  - Reset mid-sweep aborts the sweep.

Optional Feature:
- Macro BTB_STATS_EN.
- Defined: adds outputs stat_branches [31:0] and stat_mispredicts [31:0].
  - stat_branches increments on every u_valid.
  - stat_mispredicts increments when mispredict=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0 on rst.
  - flush does not clear them.
  - Widths are fixed so they feed the seven-segment display selector directly.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package btb_pkg:
  - FSM state typedef (ST_IDLE, ST_SWEEP);
  - function returning the weakly-taken counter init for a given CNT_W;
  - saturating increment/decrement functions.
- Natural sub-module: sat_counter (CNT_W-parametrised up/down saturating logic). It is instantiated combinationally per update, or reused for the stats counters with width 32.

Test Plan:
- Reset, then query q_pc=12'h010 → q_hit=0, q_taken=0, q_target=0, ready=1.
- Update u_pc=12'h010, u_taken=1, u_target=12'h040; next cycle query 12'h010 → q_hit=1, q_taken=1, q_target=12'h040, counter=2'b10. Query 12'h050 (same idx, different tag, ENTRIES=16) → q_hit=0.
- Three not-taken updates on 12'h010 after allocation → counter 10→01→00→00 (saturates); q_taken=0 after the first, q_hit stays 1.
- Same cycle: update 12'h020 taken to 12'h080 and query 12'h020 → q_hit=0 that cycle, q_hit=1 with target 12'h080 the next cycle.
- Fill 4 entries, pulse flush → ready=0 for exactly 16 cycles; an update issued mid-sweep is ignored; afterwards all queries miss. A second flush at sweep cycle 5 extends ready=0 to 5+16 cycles total.
- With BTB_STATS_EN: 10 updates, 3 with u_pred_taken!=u_taken, 1 with a target mismatch → stat_branches=10, stat_mispredicts=4. Pulse rst=0 asynchronously mid-run → both read 0 immediately.
